pipe_hazard_scoreboard: RTL and testbench

PIPE_HAZARD_SCOREBOARD -- requirements
Module: pipe_hazard_scoreboard

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_src_resolve.sv | 40 ++++
 rtl/pipe_hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard scoreboard.
// Entry dest fields are stored at MAX_REG_ADDR_LEN bits, zero-extended from
// the configured register-address width.
package pipe_pkg;

    localparam int unsigned DEF_REG_ADDR_LEN = 5;
    localparam int unsigned DEF_DEPTH        = 3;
    localparam int unsigned MAX_REG_ADDR_LEN = 16;

    // Operand-select code meaning "take the register file value"
    localparam int unsigned FWD_REGFILE = 0;

    typedef struct packed {
        logic                        valid;
        logic [MAX_REG_ADDR_LEN-1:0] dest;
        logic                        is_load;
    } entry_t;

endpackage

// File: rtl/pipe_src_resolve.sv
// Priority matcher for one ID source operand: finds the youngest valid
// in-flight entry writing the source register and reports whether its
// result is already forwardable from that stage.
module pipe_src_resolve
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN = DEF_REG_ADDR_LEN,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned ALU_THR      = 0,
    parameter int unsigned LOAD_THR     = 1,
    parameter int unsigned SEL_W        = 2
) (
    input  entry_t [DEPTH-1:0]      entries,
    input  logic [REG_ADDR_LEN-1:0] src,
    input  logic                    use_src,
    output logic                    hit,
    output logic                    ready,
    output logic [SEL_W-1:0]        sel
);

    logic [MAX_REG_ADDR_LEN-1:0] src_ext;

    assign src_ext = MAX_REG_ADDR_LEN'(src);

    // Scan from entry 0 upward; the first hit is the youngest producer
    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        sel   = SEL_W'(FWD_REGFILE);
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!hit && use_src && (src != '0) &&
                entries[k].valid && (entries[k].dest == src_ext)) begin
                hit   = 1'b1;
                ready = entries[k].is_load ? (k >= LOAD_THR) : (k >= ALU_THR);
                sel   = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks destinations of in-flight instructions,
// raises stall on unresolvable RAW hazards and selects forwarding sources.
// Optional feature macro: PIPE_FWD_EN (operand forwarding). Without it any
// pending producer of a used source stalls ID and fwd_sel stays 0.
module pipe_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN = DEF_REG_ADDR_LEN,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned ALU_RDY      = 0,
    parameter int unsigned LOAD_RDY     = 1,
    parameter int unsigned FLUSH_DEPTH  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [REG_ADDR_LEN-1:0]    id_rs,
    input  logic [REG_ADDR_LEN-1:0]    id_rt,
    input  logic                       id_use_rs,
    input  logic                       id_use_rt,
    input  logic                       id_reg_write,
    input  logic [REG_ADDR_LEN-1:0]    id_dest,
    input  logic                       id_is_load,
    input  logic                       flush,
    output logic                       stall,
    output logic                       issue,
    output logic [$clog2(DEPTH+1)-1:0] fwd_sel_a,
    output logic [$clog2(DEPTH+1)-1:0] fwd_sel_b,
    output logic [15:0]                stall_cnt
);

    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    // With forwarding disabled the readiness thresholds are pushed past the
    // last entry, so every match is "not ready": it stalls and never forwards.
`ifdef PIPE_FWD_EN
    localparam int unsigned ALU_THR  = ALU_RDY;
    localparam int unsigned LOAD_THR = LOAD_RDY;
`else
    localparam int unsigned ALU_THR  = DEPTH;
    localparam int unsigned LOAD_THR = DEPTH;
`endif

    if (!(DEPTH >= 1 && ALU_RDY <= LOAD_RDY && LOAD_RDY < DEPTH &&
          FLUSH_DEPTH <= DEPTH && REG_ADDR_LEN >= 1 &&
          REG_ADDR_LEN <= MAX_REG_ADDR_LEN)) begin : g_bad_config
        $error("pipe_hazard_scoreboard: illegal parameter combination");
    end

    entry_t [DEPTH-1:0] entries;
    entry_t [DEPTH-1:0] entries_nxt;

    logic             hit_a, hit_b;
    logic             ready_a, ready_b;
    logic [SEL_W-1:0] sel_a, sel_b;

    pipe_src_resolve #(
        .REG_ADDR_LEN (REG_ADDR_LEN),
        .DEPTH        (DEPTH),
        .ALU_THR      (ALU_THR),
        .LOAD_THR     (LOAD_THR),
        .SEL_W        (SEL_W)
    ) u_res_a (
        .entries (entries),
        .src     (id_rs),
        .use_src (id_use_rs),
        .hit     (hit_a),
        .ready   (ready_a),
        .sel     (sel_a)
    );

    pipe_src_resolve #(
        .REG_ADDR_LEN (REG_ADDR_LEN),
        .DEPTH        (DEPTH),
        .ALU_THR      (ALU_THR),
        .LOAD_THR     (LOAD_THR),
        .SEL_W        (SEL_W)
    ) u_res_b (
        .entries (entries),
        .src     (id_rt),
        .use_src (id_use_rt),
        .hit     (hit_b),
        .ready   (ready_b),
        .sel     (sel_b)
    );

    // Hazard decision and operand selection; flush overrides stall
    always_comb begin
        stall     = id_valid & ~flush & ((hit_a & ~ready_a) | (hit_b & ~ready_b));
        issue     = id_valid & ~stall & ~flush;
        fwd_sel_a = (hit_a & ready_a & ~stall) ? sel_a : SEL_W'(FWD_REGFILE);
        fwd_sel_b = (hit_b & ready_b & ~stall) ? sel_b : SEL_W'(FWD_REGFILE);
    end

    // Next tracker contents: ID enters entry 0, others shift, flush kills youngest
    always_comb begin
        entries_nxt            = '0;
        entries_nxt[0].valid   = issue & id_reg_write & (id_dest != '0);
        entries_nxt[0].dest    = MAX_REG_ADDR_LEN'(id_dest);
        entries_nxt[0].is_load = id_is_load;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            if (flush && ((k - 1) < FLUSH_DEPTH)) begin
                entries_nxt[k] = '0;
            end else begin
                entries_nxt[k] = entries[k-1];
            end
        end
    end

    // Tracker register
    always_ff @(posedge clk) begin
        if (rst) begin
            entries <= '0;
        end else begin
            entries <= entries_nxt;
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Self-checking bench for pipe_hazard_scoreboard (default parameters plus a
// deep instance used for the stall-counter saturation scenario).
module tb_pipe_hazard_scoreboard;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int DEPTH       = 3;
    localparam int ALU_RDY     = 0;
    localparam int LOAD_RDY    = 1;
    localparam int FLUSH_DEPTH = 1;

    localparam int S_DEPTH    = 32;
    localparam int S_LOAD_RDY = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic       rst, id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load, flush;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       stall, issue;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic [15:0] stall_cnt;

    // saturation instance signals
    logic       s_rst;
    logic       s_stall, s_issue;
    logic [5:0] s_fwd_sel_a, s_fwd_sel_b;
    logic [15:0] s_stall_cnt;

    pipe_hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_dest(id_dest), .id_is_load(id_is_load), .flush(flush),
        .stall(stall), .issue(issue), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_cnt(stall_cnt)
    );

    // Self-feeding "lw $4 <- [$4]" keeps this instance stalling most cycles
    pipe_hazard_scoreboard #(
        .REG_ADDR_LEN(5), .DEPTH(S_DEPTH), .ALU_RDY(0), .LOAD_RDY(S_LOAD_RDY), .FLUSH_DEPTH(1)
    ) dut_sat (
        .clk(clk), .rst(s_rst), .id_valid(1'b1), .id_rs(5'd4), .id_rt(5'd0),
        .id_use_rs(1'b1), .id_use_rt(1'b0), .id_reg_write(1'b1),
        .id_dest(5'd4), .id_is_load(1'b1), .flush(1'b0),
        .stall(s_stall), .issue(s_issue), .fwd_sel_a(s_fwd_sel_a), .fwd_sel_b(s_fwd_sel_b),
        .stall_cnt(s_stall_cnt)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: list of in-flight producers, index = age in stages
    typedef struct { bit v; int d; bit ld; } me_t;
    me_t m [DEPTH];
    int  m_cnt;

    logic [31:0] last_stall, last_issue, last_fa, last_fb, last_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void resolve(input bit use_src, input int src,
                                    output bit hit, output int k_o, output bit rdy);
        int need;
        hit = 0; k_o = 0; rdy = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit && use_src && src != 0 && m[k].v && m[k].d == src) begin
                hit = 1; k_o = k;
            end
        end
        if (hit) begin
            need = FWD ? (m[k_o].ld ? LOAD_RDY : ALU_RDY) : DEPTH;
            rdy  = (k_o >= need);
        end
    endfunction

    task automatic do_reset();
        rst = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_reg_write = 0; id_dest = 0; id_is_load = 0; flush = 0;
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < DEPTH; k++) begin
            m[k].v = 0; m[k].d = 0; m[k].ld = 0;
        end
        m_cnt = 0;
        chk("reset_stall_cnt", stall_cnt, 0);
    endtask

    task automatic step(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                        input bit wr, input int dst, input bit ld, input bit fl);
        bit ha, hb, ra, rb, e_stall, e_issue;
        int ka, kb, ea, eb;
        logic [31:0] tmp;
        id_valid = v; id_use_rs = urs; id_use_rt = urt; id_reg_write = wr;
        id_is_load = ld; flush = fl;
        tmp = rs;  id_rs   = tmp[4:0];
        tmp = rt;  id_rt   = tmp[4:0];
        tmp = dst; id_dest = tmp[4:0];
        #1;
        resolve(urs, rs, ha, ka, ra);
        resolve(urt, rt, hb, kb, rb);
        e_stall = v && !fl && ((ha && !ra) || (hb && !rb));
        e_issue = v && !e_stall && !fl;
        ea = (!e_stall && ha && ra) ? ka + 1 : 0;
        eb = (!e_stall && hb && rb) ? kb + 1 : 0;
        chk("stall", stall, e_stall);
        chk("issue", issue, e_issue);
        chk("fwd_sel_a", fwd_sel_a, ea);
        chk("fwd_sel_b", fwd_sel_b, eb);
        last_stall = stall; last_issue = issue; last_fa = fwd_sel_a; last_fb = fwd_sel_b;
        if (e_stall && m_cnt < 65535) m_cnt++;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (fl && (k - 1) < FLUSH_DEPTH) begin
                m[k].v = 0; m[k].d = 0; m[k].ld = 0;
            end else begin
                m[k] = m[k-1];
            end
        end
        m[0].v = e_issue && wr && dst != 0; m[0].d = dst; m[0].ld = ld;
        @(posedge clk); #1;
        chk("stall_cnt", stall_cnt, m_cnt);
        last_cnt = stall_cnt;
    endtask

    initial begin
        int s_period, n_st, e_fa;
        bit e_st;
        int exp_st [4];
        int exp_fa [4];

        s_rst = 1;
        do_reset();

        // Reset state: empty tracker, ID issues freely
        step(1, 1, 1, 2, 1, 1, 9, 0, 0);
        chk("rst_stall", last_stall, 0);
        chk("rst_issue", last_issue, 1);
        chk("rst_fwd_a", last_fa, 0);
        chk("rst_fwd_b", last_fb, 0);

        // add $3 ; add $5,$3
        do_reset();
        step(1, 1, 1, 2, 1, 1, 3, 0, 0);
        step(1, 3, 1, 0, 0, 1, 5, 0, 0);
        chk("alu_b2b_stall", last_stall, FWD ? 0 : 1);
        chk("alu_b2b_fwd_a", last_fa, FWD ? 1 : 0);

        // lw $4 ; add $6,$4,$4
        do_reset();
        step(1, 0, 0, 0, 0, 1, 4, 1, 0);
        step(1, 4, 1, 4, 1, 1, 6, 0, 0);
        chk("load_use_stall", last_stall, 1);
        step(1, 4, 1, 4, 1, 1, 6, 0, 0);
        chk("load_use_stall2", last_stall, FWD ? 0 : 1);
        chk("load_use_fwd_a", last_fa, FWD ? 2 : 0);
        chk("load_use_fwd_b", last_fb, FWD ? 2 : 0);
        chk("load_use_cnt", last_cnt, FWD ? 1 : 2);

        // add $3 ; then a non-writing reader of $3 held for four cycles
        do_reset();
        step(1, 0, 0, 0, 0, 1, 3, 0, 0);
        exp_st = FWD ? '{0, 0, 0, 0} : '{1, 1, 1, 0};
        exp_fa = FWD ? '{1, 2, 3, 0} : '{0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            step(1, 3, 1, 0, 0, 0, 0, 0, 0);
            chk("age_stall", last_stall, exp_st[i]);
            chk("age_fwd_a", last_fa, exp_fa[i]);
        end

        // add $7 ; nop ; add $8,$0,$7
        do_reset();
        step(1, 0, 0, 0, 0, 1, 7, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 7, 1, 1, 8, 0, 0);
        chk("gap_fwd_a", last_fa, 0);
        chk("gap_fwd_b", last_fb, FWD ? 2 : 0);
        chk("gap_stall", last_stall, FWD ? 0 : 1);

        // write $0 then read $0: never a hazard
        do_reset();
        step(1, 0, 0, 0, 0, 1, 0, 1, 0);
        step(1, 0, 1, 0, 1, 1, 2, 0, 0);
        chk("r0_stall", last_stall, 0);
        chk("r0_fwd_a", last_fa, 0);

        // flush during load-use stall kills the load; no stale forward after
        do_reset();
        step(1, 0, 0, 0, 0, 1, 4, 1, 0);
        step(1, 4, 1, 0, 0, 1, 6, 0, 1);
        chk("flush_stall", last_stall, 0);
        chk("flush_issue", last_issue, 0);
        step(1, 4, 1, 4, 1, 1, 6, 0, 0);
        chk("post_flush_stall", last_stall, 0);
        chk("post_flush_fwd_a", last_fa, 0);
        chk("post_flush_issue", last_issue, 1);

        // reset in the middle of a stall leaves no residue
        do_reset();
        step(1, 0, 0, 0, 0, 1, 4, 1, 0);
        step(1, 4, 1, 0, 0, 1, 6, 0, 0);
        chk("mid_stall", last_stall, 1);
        do_reset();
        step(1, 4, 1, 0, 0, 1, 6, 0, 0);
        chk("after_rst_stall", last_stall, 0);
        chk("after_rst_fwd_a", last_fa, 0);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(63) == 0) do_reset();
            step($urandom_range(7) != 0, int'($urandom_range(7)), $urandom_range(3) != 0,
                 int'($urandom_range(7)), $urandom_range(1) != 0, $urandom_range(3) != 0,
                 int'($urandom_range(7)), $urandom_range(2) == 0, $urandom_range(9) == 0);
        end

        // stall counter saturation on the deep instance
        s_period = (FWD ? S_LOAD_RDY : S_DEPTH) + 1;
        n_st = 0;
        s_rst = 0;
        for (int t = 0; t < 68000; t++) begin
            e_st = (t % s_period) != 0;
            e_fa = (!e_st && t > 0 && FWD) ? S_DEPTH : 0;
            chk("sat_stall", s_stall, e_st);
            chk("sat_fwd_a", s_fwd_sel_a, e_fa);
            chk("sat_fwd_b", s_fwd_sel_b, 0);
            if (e_st) n_st++;
            @(posedge clk); #1;
            if (t % 4096 == 0) chk("sat_cnt_mid", s_stall_cnt, (n_st > 65535) ? 65535 : n_st);
        end
        chk("sat_cnt_final", s_stall_cnt, 16'hFFFF);
        s_rst = 1;
        @(posedge clk); #1;
        s_rst = 0;
        chk("sat_cnt_reset", s_stall_cnt, 0);
        chk("sat_rst_stall", s_stall, 0);
        chk("sat_rst_issue", s_issue, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
